maxpooling: RTL and testbench
=============================

// Module: maxpooling
// PURPOSE
//  2x2 stride-2 max pooling stage for the encoder path of the segmentation CNN.
//  Takes a raster-order pixel stream (UNITS channels per pixel) with coordinates.
//  Emits one pixel per 2x2 block at half resolution, each channel the signed maximum of its four inputs.
//  Feeds the next encoder layer; the matching decoder unpooling stage restores resolution.
// PARAMETERS
//  WIDTH      -1  input frame width in pixels; even, >=4
//  HEIGHT     -1  input frame height in lines; even, >=4
//  FIXED_BITW -1  bits per channel, two's complement
//  UNITS      -1  channels per pixel
// PORTS
//  clock       in   1                  clock
//  n_rst       in   1                  asynchronous, active-low reset
//  in_enable   in   1                  in_pixels/in_vcnt/in_hcnt valid this cycle
//  in_pixels   in   FIXED_BITW*UNITS   channel 0 in bits [0:FIXED_BITW-1], then channel 1, ...
//  in_vcnt     in   log2(HEIGHT)       input line index
//  in_hcnt     in   log2(WIDTH)        input column index
//  out_enable  out  1                  one-cycle pulse per pooled pixel
//  out_pixels  out  FIXED_BITW*UNITS   per-channel max, same packing as in_pixels
//  out_vcnt    out  log2(HEIGHT)-1     in_vcnt>>1 of the block
//  out_hcnt    out  log2(WIDTH)-1      in_hcnt>>1 of the block
// BEHAVIOUR
//  - Reset: out_enable=0, out_pixels=0, out_vcnt=0, out_hcnt=0, FSM=SYNC, pair register=0.
//  - Inputs are sampled only when in_enable=1; cycles with in_enable=0 are ignored and change no state.
//  - Pair register: at even in_hcnt, store in_pixels as P0.
//  - Even row (vcnt[0]=0), odd hcnt: write max(P0, in) per channel to line buffer address hcnt>>1.
//  - Odd row, even hcnt: issue a synchronous read of buffer address hcnt>>1.
//  - Odd row, odd hcnt: result = max(buffer word, P0, in) per channel.
//  - Latency: out_enable rises exactly 2 clocks after the odd-row odd-column in_enable beat.
//    Stage 1 registers the three operands; stage 2 registers the max and the coordinates.
//  - Comparison: signed, per channel, FIXED_BITW wide. No rounding or saturation; ties take either (equal) value.
//  - Outputs hold their last value while out_enable=0.
//  - FSM states:
//      SYNC: outputs suppressed; go to EVEN on in_enable with vcnt=0 and hcnt=0.
//      EVEN: go to ODD on in_enable with odd vcnt and hcnt=0.
//      ODD:  produce outputs; go to EVEN on in_enable with even vcnt and hcnt=0.
//  - Coordinate discontinuity forces SYNC: any accepted hcnt=0 whose vcnt parity disagrees with the state.
//  - Stalls: arbitrary in_enable=0 gaps, including between the two pixels of a pair or between rows, are legal.
//  - Wrap: vcnt=HEIGHT-1, hcnt=WIDTH-1 produces the last block (HEIGHT/2-1, WIDTH/2-1).
//    The next beat at (0,0) re-enters EVEN without passing through SYNC.
//  - Simultaneous write and read: the buffer is never read and written in the same row, so no bypass is needed.
//  - Reset mid-frame: the buffer is not cleared. No output until the next frame start at (0,0).
//    Results from a partially filled buffer are never emitted.
//  - The odd-row read of a column always follows the even-row write of the same column in the same frame.
// STRUCTURE
//  - Shared include: the log2 (ceil) function and the channel-slice helper, used across all layer modules.
//  - Sub-module pool_line_buffer: simple dual-port synchronous RAM.
//    Depth WIDTH/2, width FIXED_BITW*UNITS, one write port, one registered read port, no reset on storage.
//  - Top level holds the FSM, the pair register, a per-channel generate loop of signed max, and the 2-stage output pipe.
// TESTING
//  1. WIDTH=4, HEIGHT=4, UNITS=1, FIXED_BITW=8, continuous in_enable, pixel = raster index 0..15.
//     -> 4 pulses, values 5,7,13,15 at (0,0),(0,1),(1,0),(1,1), each 2 clk after its input.
//  2. Same frame with signed values: block {-3,-128,-1,-7}.
//     -> output -1; block all -128 -> output -128.
//  3. UNITS=3, channels ramping in opposite directions.
//     -> each channel maxed independently; no cross-channel mixing.
//  4. Random 0-5 cycle in_enable gaps inserted in test 1.
//     -> identical values and coordinates; each pulse 2 clk after its completing beat.
//  5. Assert n_rst at row 1 of frame 1, release, resume at row 2.
//     -> no out_enable until frame 2 (0,0); frame 2 outputs are correct.
//  6. WIDTH=640, HEIGHT=480, two back-to-back frames.
//     -> 320*240 pulses per frame; last is (239,319); frame 2 starts with no SYNC gap.

Source files
------------

// File: rtl/maxpooling_pkg.sv
// Shared helpers for the encoder layer modules: ceiling log2, channel slice offsets
// and the pooling FSM state type.
package maxpooling_pkg;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_EVEN = 2'd1,
        ST_ODD  = 2'd2
    } pool_state_e;

    function automatic int log2c(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int chan_lsb(input int ch, input int bitw);
        return ch * bitw;
    endfunction

endpackage

// File: rtl/maxpooling_line_buffer.sv
// Half-width line store for the pooling stage: one write port, one registered read port.
// Storage has no reset; every word is rewritten on an even row before it is read.
module pool_line_buffer #(
    parameter int DEPTH  = 2,
    parameter int DWIDTH = 8,
    parameter int ABITS  = 1
) (
    input  logic              clock,
    input  logic              i_wr_en,
    input  logic [ABITS-1:0]  i_wr_addr,
    input  logic [DWIDTH-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ABITS-1:0]  i_rd_addr,
    output logic [DWIDTH-1:0] o_rd_data
);

    logic [DWIDTH-1:0] r_mem [DEPTH];

    // Storage write and registered read; read data holds between reads
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/maxpooling.sv
// 2x2 stride-2 signed max pooling over a raster pixel stream with UNITS channels per pixel.
// Even rows leave pair maxima in the line buffer; odd rows complete the block through a 2-stage pipe.
module maxpooling
    import maxpooling_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int HEIGHT     = 4,
    parameter int FIXED_BITW = 8,
    parameter int UNITS      = 1
) (
    input  logic                          clock,
    input  logic                          n_rst,
    input  logic                          in_enable,
    input  logic [FIXED_BITW*UNITS-1:0]   in_pixels,
    input  logic [log2c(HEIGHT)-1:0]      in_vcnt,
    input  logic [log2c(WIDTH)-1:0]       in_hcnt,
    output logic                          out_enable,
    output logic [FIXED_BITW*UNITS-1:0]   out_pixels,
    output logic [log2c(HEIGHT)-2:0]      out_vcnt,
    output logic [log2c(WIDTH)-2:0]       out_hcnt
);

    localparam int VBITS = log2c(HEIGHT);
    localparam int HBITS = log2c(WIDTH);
    localparam int PBITS = FIXED_BITW * UNITS;

    pool_state_e        r_state;
    pool_state_e        w_state_next;
    logic               w_write;
    logic               w_read;
    logic               w_emit;
    logic [PBITS-1:0]   r_p0;
    logic [PBITS-1:0]   w_pair_max;
    logic [PBITS-1:0]   w_buf_q;
    logic [PBITS-1:0]   w_blk_max;
    logic               r_s1_valid;
    logic [PBITS-1:0]   r_s1_buf;
    logic [PBITS-1:0]   r_s1_p0;
    logic [PBITS-1:0]   r_s1_in;
    logic [VBITS-2:0]   r_s1_vcnt;
    logic [HBITS-2:0]   r_s1_hcnt;

    // Next state, buffer strobes and emit decision for the beat on the inputs
    always_comb begin
        w_state_next = r_state;
        w_write      = 1'b0;
        w_read       = 1'b0;
        w_emit       = 1'b0;
        if (in_enable) begin
            w_write = (r_state == ST_EVEN) && !in_vcnt[0] && in_hcnt[0];
            w_read  = in_vcnt[0] && !in_hcnt[0];
            w_emit  = (r_state == ST_ODD) && in_vcnt[0] && in_hcnt[0];
            // A row start must alternate parity with the current row, else resync
            if (in_hcnt != {HBITS{1'b0}}) begin
                w_state_next = r_state;
            end else if (in_vcnt == {VBITS{1'b0}}) begin
                w_state_next = ST_EVEN;
            end else if (in_vcnt[0] && (r_state == ST_EVEN)) begin
                w_state_next = ST_ODD;
            end else if (!in_vcnt[0] && (r_state == ST_ODD)) begin
                w_state_next = ST_EVEN;
            end else begin
                w_state_next = ST_SYNC;
            end
        end else begin
            w_state_next = r_state;
        end
    end

    // FSM state and the even-column pair register
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_SYNC;
            r_p0    <= {PBITS{1'b0}};
        end else begin
            r_state <= w_state_next;
            if (in_enable && !in_hcnt[0]) begin
                r_p0 <= in_pixels;
            end
        end
    end

    pool_line_buffer #(
        .DEPTH  (WIDTH / 2),
        .DWIDTH (PBITS),
        .ABITS  (HBITS - 1)
    ) u_line_buffer (
        .clock     (clock),
        .i_wr_en   (w_write),
        .i_wr_addr (in_hcnt[HBITS-1:1]),
        .i_wr_data (w_pair_max),
        .i_rd_en   (w_read),
        .i_rd_addr (in_hcnt[HBITS-1:1]),
        .o_rd_data (w_buf_q)
    );

    for (genvar c = 0; c < UNITS; c++) begin : g_chan
        localparam int LSB = chan_lsb(c, FIXED_BITW);
        logic signed [FIXED_BITW-1:0] w_p0;
        logic signed [FIXED_BITW-1:0] w_in;
        logic signed [FIXED_BITW-1:0] w_buf;
        logic signed [FIXED_BITW-1:0] w_s1_p0;
        logic signed [FIXED_BITW-1:0] w_s1_in;
        logic signed [FIXED_BITW-1:0] w_s1_pair;

        assign w_p0      = r_p0[LSB +: FIXED_BITW];
        assign w_in      = in_pixels[LSB +: FIXED_BITW];
        assign w_pair_max[LSB +: FIXED_BITW] = (w_p0 > w_in) ? w_p0 : w_in;

        assign w_buf     = r_s1_buf[LSB +: FIXED_BITW];
        assign w_s1_p0   = r_s1_p0[LSB +: FIXED_BITW];
        assign w_s1_in   = r_s1_in[LSB +: FIXED_BITW];
        assign w_s1_pair = (w_s1_p0 > w_s1_in) ? w_s1_p0 : w_s1_in;
        assign w_blk_max[LSB +: FIXED_BITW] = (w_buf > w_s1_pair) ? w_buf : w_s1_pair;
    end

    // Stage 1: capture the three operands and block coordinates of a completing beat
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_buf   <= {PBITS{1'b0}};
            r_s1_p0    <= {PBITS{1'b0}};
            r_s1_in    <= {PBITS{1'b0}};
            r_s1_vcnt  <= {(VBITS-1){1'b0}};
            r_s1_hcnt  <= {(HBITS-1){1'b0}};
        end else begin
            r_s1_valid <= w_emit;
            if (w_emit) begin
                r_s1_buf  <= w_buf_q;
                r_s1_p0   <= r_p0;
                r_s1_in   <= in_pixels;
                r_s1_vcnt <= in_vcnt[VBITS-1:1];
                r_s1_hcnt <= in_hcnt[HBITS-1:1];
            end
        end
    end

    // Stage 2: register the block maximum; outputs hold between pulses
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            out_enable <= 1'b0;
            out_pixels <= {PBITS{1'b0}};
            out_vcnt   <= {(VBITS-1){1'b0}};
            out_hcnt   <= {(HBITS-1){1'b0}};
        end else begin
            out_enable <= r_s1_valid;
            if (r_s1_valid) begin
                out_pixels <= w_blk_max;
                out_vcnt   <= r_s1_vcnt;
                out_hcnt   <= r_s1_hcnt;
            end
        end
    end

endmodule

// File: tb/tb_maxpooling.sv
// Scoreboard bench for maxpooling: a 4x4 frame, 3 signed 8-bit channels per pixel.
// Expected blocks (value, coordinates, arrival cycle) are queued as the completing beat is driven.
module tb_maxpooling;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int BW = 8;
    localparam int U  = 3;
    localparam int PB = BW * U;

    typedef struct packed {
        logic [PB-1:0] px;
        logic [0:0]    v;
        logic [0:0]    h;
        logic [31:0]   cyc;
    } ev_t;

    logic          clock     = 1'b0;
    logic          n_rst     = 1'b1;
    logic          in_enable = 1'b0;
    logic [PB-1:0] in_pixels = '0;
    logic [1:0]    in_vcnt   = '0;
    logic [1:0]    in_hcnt   = '0;
    logic          out_enable;
    logic [PB-1:0] out_pixels;
    logic [0:0]    out_vcnt;
    logic [0:0]    out_hcnt;

    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    int            base;
    logic [PB-1:0] frame [W*H];
    ev_t           exp_q[$];
    ev_t           got_q[$];

    maxpooling #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .FIXED_BITW (BW),
        .UNITS      (U)
    ) dut (
        .clock      (clock),
        .n_rst      (n_rst),
        .in_enable  (in_enable),
        .in_pixels  (in_pixels),
        .in_vcnt    (in_vcnt),
        .in_hcnt    (in_hcnt),
        .out_enable (out_enable),
        .out_pixels (out_pixels),
        .out_vcnt   (out_vcnt),
        .out_hcnt   (out_hcnt)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (out_enable) begin
            ev_t g;
            g.px  = out_pixels;
            g.v   = out_vcnt;
            g.h   = out_hcnt;
            g.cyc = 32'(cyc);
            got_q.push_back(g);
        end
    end

    // Reference: per-channel signed max of the 2x2 block whose bottom-right pixel is (v,h)
    function automatic logic [PB-1:0] blk_max(input int v, input int h);
        logic [PB-1:0]         r;
        logic signed [BW-1:0]  m;
        logic signed [BW-1:0]  x;
        int                    idx [4];
        idx[0] = (v - 1) * W + h - 1;
        idx[1] = (v - 1) * W + h;
        idx[2] = v * W + h - 1;
        idx[3] = v * W + h;
        r = '0;
        for (int c = 0; c < U; c++) begin
            m = frame[idx[0]][c*BW +: BW];
            for (int k = 1; k < 4; k++) begin
                x = frame[idx[k]][c*BW +: BW];
                if (x > m) m = x;
            end
            r[c*BW +: BW] = m;
        end
        return r;
    endfunction

    task automatic drive_beat(input int v, input int h, input int gap, input bit arm);
        ev_t e;
        for (int g = 0; g < gap; g++) begin
            @(negedge clock);
            in_enable = 1'b0;
            in_pixels = PB'($urandom);
            in_vcnt   = 2'($urandom);
            in_hcnt   = 2'($urandom);
        end
        @(negedge clock);
        in_enable = 1'b1;
        in_pixels = frame[v*W + h];
        in_vcnt   = 2'(v);
        in_hcnt   = 2'(h);
        if (arm && (v % 2 == 1) && (h % 2 == 1)) begin
            e.px  = blk_max(v, h);
            e.v   = 1'(v / 2);
            e.h   = 1'(h / 2);
            e.cyc = 32'(cyc + 2);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_frame(input int max_gap, input int row_lo, input bit arm);
        for (int v = row_lo; v < H; v++) begin
            for (int h = 0; h < W; h++) begin
                drive_beat(v, h, (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0, arm);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            in_enable = 1'b0;
        end
    endtask

    task automatic test_reset;
        #2 n_rst = 1'b0;
        idle(3);
        n_checks++;
        if (out_enable !== 1'b0) $display("FAIL reset_enable: got %b, required 0", out_enable);
        else n_pass++;
        n_checks++;
        if (out_pixels !== '0) $display("FAIL reset_pixels: got %h, required 0", out_pixels);
        else n_pass++;
        n_checks++;
        if (out_vcnt !== 1'b0) $display("FAIL reset_vcnt: got %0d, required 0", out_vcnt);
        else n_pass++;
        n_checks++;
        if (out_hcnt !== 1'b0) $display("FAIL reset_hcnt: got %0d, required 0", out_hcnt);
        else n_pass++;
        n_rst = 1'b1;
        idle(2);
    endtask

    task automatic test_raster;
        logic [PB-1:0] last_px;
        for (int i = 0; i < W*H; i++) frame[i] = {16'd0, 8'(i)};
        base = got_q.size();
        drive_frame(0, 0, 1'b1);
        idle(6);
        n_checks++;
        if (got_q.size() - base !== exp_q.size())
            $display("FAIL raster_count: got %0d pulses, required %0d", got_q.size() - base, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[base+i] !== exp_q[i])
                $display("FAIL raster_pulse%0d: got %h, required %h", i, got_q[base+i], exp_q[i]);
            else n_pass++;
        end
        last_px = exp_q[exp_q.size()-1].px;
        n_checks++;
        if (out_pixels !== last_px) $display("FAIL raster_hold: got %h, required %h", out_pixels, last_px);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_signed;
        for (int i = 0; i < W*H; i++) frame[i] = PB'($urandom);
        frame[0][7:0] = 8'hFD;
        frame[1][7:0] = 8'h80;
        frame[4][7:0] = 8'hFF;
        frame[5][7:0] = 8'hF9;
        frame[2][7:0] = 8'h80;
        frame[3][7:0] = 8'h80;
        frame[6][7:0] = 8'h80;
        frame[7][7:0] = 8'h80;
        base = got_q.size();
        drive_frame(0, 0, 1'b1);
        idle(6);
        n_checks++;
        if (got_q.size() - base !== exp_q.size())
            $display("FAIL signed_count: got %0d pulses, required %0d", got_q.size() - base, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[base+i] !== exp_q[i])
                $display("FAIL signed_pulse%0d: got %h, required %h", i, got_q[base+i], exp_q[i]);
            else n_pass++;
        end
        exp_q.delete();
    endtask

    task automatic test_channels;
        for (int i = 0; i < W*H; i++) frame[i] = {8'(i * 5), 8'(60 - i * 9), 8'(i * 9 - 64)};
        base = got_q.size();
        drive_frame(0, 0, 1'b1);
        idle(6);
        n_checks++;
        if (got_q.size() - base !== exp_q.size())
            $display("FAIL channels_count: got %0d pulses, required %0d", got_q.size() - base, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[base+i] !== exp_q[i])
                $display("FAIL channels_pulse%0d: got %h, required %h", i, got_q[base+i], exp_q[i]);
            else n_pass++;
        end
        exp_q.delete();
    endtask

    task automatic test_gaps;
        for (int i = 0; i < W*H; i++) frame[i] = {16'd0, 8'(i)};
        base = got_q.size();
        drive_frame(5, 0, 1'b1);
        idle(6);
        n_checks++;
        if (got_q.size() - base !== exp_q.size())
            $display("FAIL gaps_count: got %0d pulses, required %0d", got_q.size() - base, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[base+i] !== exp_q[i])
                $display("FAIL gaps_pulse%0d: got %h, required %h", i, got_q[base+i], exp_q[i]);
            else n_pass++;
        end
        exp_q.delete();
    endtask

    task automatic test_reset_midframe;
        for (int i = 0; i < W*H; i++) frame[i] = PB'($urandom);
        base = got_q.size();
        for (int h = 0; h < W; h++) drive_beat(0, h, 0, 1'b0);
        drive_beat(1, 0, 0, 1'b0);
        drive_beat(1, 1, 0, 1'b0);
        @(negedge clock);
        in_enable = 1'b0;
        n_rst     = 1'b0;
        @(negedge clock);
        n_checks++;
        if (out_enable !== 1'b0) $display("FAIL midreset_enable: got %b, required 0", out_enable);
        else n_pass++;
        n_rst = 1'b1;
        drive_frame(0, 2, 1'b0);
        idle(6);
        n_checks++;
        if (got_q.size() - base !== 0)
            $display("FAIL midreset_quiet: got %0d pulses, required 0", got_q.size() - base);
        else n_pass++;
        for (int i = 0; i < W*H; i++) frame[i] = PB'($urandom);
        base = got_q.size();
        drive_frame(0, 0, 1'b1);
        idle(6);
        n_checks++;
        if (got_q.size() - base !== exp_q.size())
            $display("FAIL midreset_count: got %0d pulses, required %0d", got_q.size() - base, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[base+i] !== exp_q[i])
                $display("FAIL midreset_pulse%0d: got %h, required %h", i, got_q[base+i], exp_q[i]);
            else n_pass++;
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        base = got_q.size();
        for (int i = 0; i < W*H; i++) frame[i] = PB'($urandom);
        drive_frame(0, 0, 1'b1);
        for (int i = 0; i < W*H; i++) frame[i] = PB'($urandom);
        drive_frame(0, 0, 1'b1);
        idle(6);
        n_checks++;
        if (got_q.size() - base !== 2 * (W/2) * (H/2))
            $display("FAIL b2b_count: got %0d pulses, required %0d", got_q.size() - base, 2 * (W/2) * (H/2));
        else n_pass++;
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[base+i] !== exp_q[i])
                $display("FAIL b2b_pulse%0d: got %h, required %h", i, got_q[base+i], exp_q[i]);
            else n_pass++;
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_raster();
        test_signed();
        test_channels();
        test_gaps();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
